unstripe_lane_scheduler: RTL and testbench

Sequencing controller for the two-lane un-striping path, running in the `clk_2f` domain. It absorbs words from `lane_0` and `lane_1` into small per-lane FIFOs and re-issues them as one strictly interleaved stream: lane 0, lane 1, lane 0, and so on. It tolerates bounded inter-lane skew and flags skew timeouts and overflows. It sits between the lane receivers and the downstream `data_out` / `valid_out` consumer.

---
 rtl/unstripe_lane_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_unstripe_lane_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/unstripe_lane_scheduler.sv
// Two-lane un-striping scheduler: buffers each lane in a small FIFO and re-issues
// words strictly as lane 0, lane 1, lane 0, ... with sticky skew/overflow flags.
module unstripe_lane_scheduler #(
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk_2f,
    input  logic          reset,
    input  logic [DW-1:0] lane_0,
    input  logic          valid_0,
    input  logic [DW-1:0] lane_1,
    input  logic          valid_1,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          lane_sel,
    output logic          busy,
    output logic          skew_err,
    output logic          ovf_0,
    output logic          ovf_1
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [7:0]    WAIT_LIM = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem0_q [DEPTH];
    logic [DW-1:0] mem0_d [DEPTH];
    logic [DW-1:0] mem1_q [DEPTH];
    logic [DW-1:0] mem1_d [DEPTH];
    logic [AW-1:0] wptr0_q, wptr0_d, rptr0_q, rptr0_d;
    logic [AW-1:0] wptr1_q, wptr1_d, rptr1_q, rptr1_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          lane_sel_q, lane_sel_d;
    logic [7:0]    wait_q, wait_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          skew_q, skew_d;
    logic          ovf0_q, ovf0_d;
    logic          ovf1_q, ovf1_d;

    logic          empty0_s, empty1_s, full0_s, full1_s;
    logic          pop_cand0_s, pop_cand1_s, over0_s, over1_s;
    logic          wait_inc_s, timeout_s;
    logic [7:0]    wait_next_s;
    logic          push0_s, push1_s, pop0_s, pop1_s, flush_s;

    // FIFO status and RUN-state pop/overflow/stall qualifiers
    always_comb begin
        empty0_s    = (cnt0_q == {CW{1'b0}});
        empty1_s    = (cnt1_q == {CW{1'b0}});
        full0_s     = (cnt0_q == CNT_FULL);
        full1_s     = (cnt1_q == CNT_FULL);
        pop_cand0_s = !lane_sel_q && !empty0_s;
        pop_cand1_s = lane_sel_q && !empty1_s;
        // a pop from a full FIFO frees the slot the same-edge push lands in
        over0_s     = valid_0 && full0_s && !pop_cand0_s;
        over1_s     = valid_1 && full1_s && !pop_cand1_s;
        wait_inc_s  = lane_sel_q ? (empty1_s && !empty0_s) : (empty0_s && !empty1_s);
        wait_next_s = wait_q + 8'd1;
        timeout_s   = wait_inc_s && (wait_next_s >= WAIT_LIM);
    end

    // Sequencing FSM next state, output staging and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        mem0_d     = mem0_q;
        mem1_d     = mem1_q;
        wptr0_d    = wptr0_q;
        rptr0_d    = rptr0_q;
        wptr1_d    = wptr1_q;
        rptr1_d    = rptr1_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        lane_sel_d = lane_sel_q;
        wait_d     = wait_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        skew_d     = skew_q;
        ovf0_d     = ovf0_q;
        ovf1_d     = ovf1_q;
        push0_s    = 1'b0;
        push1_s    = 1'b0;
        pop0_s     = 1'b0;
        pop1_s     = 1'b0;
        flush_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lane_sel_d = 1'b0;
                wait_d     = 8'd0;
                if (valid_0 && full0_s) begin
                    ovf0_d  = 1'b1;
                    state_d = ST_ERROR;
                end else if (valid_0 || !empty0_s) begin
                    push0_s = valid_0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (over0_s || over1_s || timeout_s) begin
                    ovf0_d  = ovf0_q | over0_s;
                    ovf1_d  = ovf1_q | over1_s;
                    skew_d  = skew_q | timeout_s;
                    wait_d  = 8'd0;
                    state_d = ST_ERROR;
                end else begin
                    push0_s = valid_0;
                    push1_s = valid_1;
                    if (pop_cand0_s || pop_cand1_s) begin
                        pop0_s     = pop_cand0_s;
                        pop1_s     = pop_cand1_s;
                        data_d     = lane_sel_q ? mem1_q[rptr1_q] : mem0_q[rptr0_q];
                        valid_d    = 1'b1;
                        lane_sel_d = !lane_sel_q;
                        wait_d     = 8'd0;
                    end else if (wait_inc_s) begin
                        wait_d = wait_next_s;
                    end else begin
                        wait_d = wait_q;
                    end
                    if (empty0_s && empty1_s && !valid_0 && !valid_1 && !lane_sel_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_ERROR: begin
                flush_s    = 1'b1;
                lane_sel_d = 1'b0;
                wait_d     = 8'd0;
                state_d    = ST_IDLE;
            end
            default: begin
                flush_s    = 1'b1;
                lane_sel_d = 1'b0;
                wait_d     = 8'd0;
                state_d    = ST_IDLE;
            end
        endcase

        if (flush_s) begin
            wptr0_d = {AW{1'b0}};
            rptr0_d = {AW{1'b0}};
            cnt0_d  = {CW{1'b0}};
            wptr1_d = {AW{1'b0}};
            rptr1_d = {AW{1'b0}};
            cnt1_d  = {CW{1'b0}};
        end else begin
            if (push0_s) begin
                mem0_d[wptr0_q] = lane_0;
                wptr0_d         = wptr0_q + AW'(1);
            end else begin
                wptr0_d = wptr0_q;
            end
            if (push1_s) begin
                mem1_d[wptr1_q] = lane_1;
                wptr1_d         = wptr1_q + AW'(1);
            end else begin
                wptr1_d = wptr1_q;
            end
            if (pop0_s) begin
                rptr0_d = rptr0_q + AW'(1);
            end else begin
                rptr0_d = rptr0_q;
            end
            if (pop1_s) begin
                rptr1_d = rptr1_q + AW'(1);
            end else begin
                rptr1_d = rptr1_q;
            end
            case ({push0_s, pop0_s})
                2'b10:   cnt0_d = cnt0_q + CW'(1);
                2'b01:   cnt0_d = cnt0_q - CW'(1);
                default: cnt0_d = cnt0_q;
            endcase
            case ({push1_s, pop1_s})
                2'b10:   cnt1_d = cnt1_q + CW'(1);
                2'b01:   cnt1_d = cnt1_q - CW'(1);
                default: cnt1_d = cnt1_q;
            endcase
        end
    end

    // State, FIFO and output registers with synchronous reset
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mem0_q     <= '{default: '0};
            mem1_q     <= '{default: '0};
            wptr0_q    <= {AW{1'b0}};
            rptr0_q    <= {AW{1'b0}};
            wptr1_q    <= {AW{1'b0}};
            rptr1_q    <= {AW{1'b0}};
            cnt0_q     <= {CW{1'b0}};
            cnt1_q     <= {CW{1'b0}};
            lane_sel_q <= 1'b0;
            wait_q     <= 8'd0;
            data_q     <= {DW{1'b0}};
            valid_q    <= 1'b0;
            skew_q     <= 1'b0;
            ovf0_q     <= 1'b0;
            ovf1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            wptr0_q    <= wptr0_d;
            rptr0_q    <= rptr0_d;
            wptr1_q    <= wptr1_d;
            rptr1_q    <= rptr1_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            lane_sel_q <= lane_sel_d;
            wait_q     <= wait_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            skew_q     <= skew_d;
            ovf0_q     <= ovf0_d;
            ovf1_q     <= ovf1_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lane_sel  = lane_sel_q;
    assign busy      = (state_q != ST_IDLE);
    assign skew_err  = skew_q;
    assign ovf_0     = ovf0_q;
    assign ovf_1     = ovf1_q;

endmodule

// File: tb/tb_unstripe_lane_scheduler.sv
// Scoreboard bench for unstripe_lane_scheduler: per-lane expected queues are
// filled at stimulus time and consumed in interleaved order as valid_out fires.
module tb_unstripe_lane_scheduler;
    localparam int DW       = 32;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic          clk_2f = 1'b0;
    logic          reset;
    logic [DW-1:0] lane_0, lane_1;
    logic          valid_0, valid_1;
    logic [DW-1:0] data_out;
    logic          valid_out, lane_sel, busy, skew_err, ovf_0, ovf_1;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    logic          exp_sel = 1'b0;

    always #5 clk_2f = ~clk_2f;

    unstripe_lane_scheduler #(.DW(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .lane_0   (lane_0),
        .valid_0  (valid_0),
        .lane_1   (lane_1),
        .valid_1  (valid_1),
        .data_out (data_out),
        .valid_out(valid_out),
        .lane_sel (lane_sel),
        .busy     (busy),
        .skew_err (skew_err),
        .ovf_0    (ovf_0),
        .ovf_1    (ovf_1)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive one cycle; e0/e1 mark words that must later appear on data_out
    task automatic step(input logic v0, input logic [DW-1:0] d0,
                        input logic v1, input logic [DW-1:0] d1,
                        input logic e0, input logic e1);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
        if (e0) exp0.push_back(d0);
        if (e1) exp1.push_back(d1);
        @(posedge clk_2f);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic clear_model();
        exp0.delete();
        exp1.delete();
        exp_sel = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check_eq(tag, DW'(exp0.size() + exp1.size()), 32'd0);
    endtask

    task automatic pair_stream(input logic [DW-1:0] a, input logic [DW-1:0] b);
        step(1'b1, a, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, b, 1'b0, 1'b1);
        idle(4);
    endtask

    // output monitor: every valid_out word must be the head of the expected lane queue
    always @(negedge clk_2f) begin
        if (valid_out === 1'b1) begin
            if (exp_sel == 1'b0) begin
                if (exp0.size() == 0) check_eq("spurious_out0", DW'(valid_out), 32'd0);
                else check_eq("order_lane0", data_out, exp0.pop_front());
            end else begin
                if (exp1.size() == 0) check_eq("spurious_out1", DW'(valid_out), 32'd0);
                else check_eq("order_lane1", data_out, exp1.pop_front());
            end
            exp_sel = ~exp_sel;
        end
    end

    initial begin
        reset   = 1'b1;
        lane_0  = 32'h0;
        lane_1  = 32'h0;
        valid_0 = 1'b0;
        valid_1 = 1'b0;

        // reset with lanes toggling
        step(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        step(1'b0, 32'h3333_3333, 1'b1, 32'h4444_4444, 1'b0, 1'b0);
        check_eq("rst_data", data_out, 32'h0);
        check_eq("rst_valid", DW'(valid_out), 32'd0);
        check_eq("rst_busy", DW'(busy), 32'd0);
        check_eq("rst_sel", DW'(lane_sel), 32'd0);
        check_eq("rst_skew", DW'(skew_err), 32'd0);
        check_eq("rst_ovf0", DW'(ovf_0), 32'd0);
        check_eq("rst_ovf1", DW'(ovf_1), 32'd0);
        reset = 1'b0;
        idle(3);
        check_eq("quiet_busy", DW'(busy), 32'd0);

        // nominal interleave and 2-cycle latency
        clear_model();
        step(1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("nom_lat_early", DW'(valid_out), 32'd0);
        check_eq("nom_busy", DW'(busy), 32'd1);
        step(1'b0, 32'h0, 1'b1, 32'hB000_0000, 1'b0, 1'b1);
        check_eq("nom_lat", DW'(valid_out), 32'd1);
        step(1'b1, 32'hA000_0001, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'hB000_0001, 1'b0, 1'b1);
        idle(4);
        check_eq("nom_idle", DW'(busy), 32'd0);
        check_drained("nom_drain");

        // lane 1 lags lane 0 by 3 cycles, 8 words total
        clear_model();
        for (int c = 0; c < 10; c++) begin
            step((c < 8) && (c % 2 == 0), 32'hC000_0000 + DW'(c / 2),
                 (c >= 3) && (c % 2 == 1), 32'hD000_0000 + DW'((c - 3) / 2),
                 (c < 8) && (c % 2 == 0), (c >= 3) && (c % 2 == 1));
        end
        idle(6);
        check_drained("skew_drain");
        check_eq("skew_no_err", DW'(skew_err), 32'd0);
        check_eq("skew_no_ovf0", DW'(ovf_0), 32'd0);
        check_eq("skew_no_ovf1", DW'(ovf_1), 32'd0);
        check_eq("skew_idle", DW'(busy), 32'd0);

        // lane 1 silent: first stall edge is the 3rd, timeout after MAX_WAIT stalls
        clear_model();
        step(1'b1, 32'hE000_0000, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'hE000_0001, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'hE000_0002, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(MAX_WAIT - 2);
        check_eq("tmo_early", DW'(skew_err), 32'd0);
        idle(1);
        check_eq("tmo_flag", DW'(skew_err), 32'd1);
        check_eq("tmo_err_busy", DW'(busy), 32'd1);
        check_eq("tmo_err_valid", DW'(valid_out), 32'd0);
        idle(1);
        check_eq("tmo_idle", DW'(busy), 32'd0);
        check_eq("tmo_sel", DW'(lane_sel), 32'd0);
        clear_model();
        idle(2);
        pair_stream(32'hE100_0000, 32'hF100_0000);
        check_drained("tmo_restart");
        check_eq("tmo_sticky", DW'(skew_err), 32'd1);

        // lane 0 overflow with lane 1 silent
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_eq("ovf_rst_skew", DW'(skew_err), 32'd0);
        clear_model();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h5000_0000 + DW'(i), 1'b0, 32'h0, i == 0, 1'b0);
            if (i == 4) check_eq("ovf_early", DW'(ovf_0), 32'd0);
        end
        check_eq("ovf_flag", DW'(ovf_0), 32'd1);
        check_eq("ovf_err_busy", DW'(busy), 32'd1);
        check_eq("ovf_err_valid", DW'(valid_out), 32'd0);
        idle(1);
        check_eq("ovf_idle", DW'(busy), 32'd0);
        check_eq("ovf_lane1", DW'(ovf_1), 32'd0);
        clear_model();
        pair_stream(32'h6000_0000, 32'h7000_0000);
        check_drained("ovf_flushed");
        check_eq("ovf_sticky", DW'(ovf_0), 32'd1);

        // lane 1 word in IDLE is discarded; reset in RUN drops buffered words
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        clear_model();
        step(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle(3);
        check_eq("align_busy", DW'(busy), 32'd0);
        check_eq("align_valid", DW'(valid_out), 32'd0);
        step(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h8000_0001, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h8000_0002, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        idle(1);
        check_eq("mid_rst_data", data_out, 32'h0);
        check_eq("mid_rst_valid", DW'(valid_out), 32'd0);
        check_eq("mid_rst_busy", DW'(busy), 32'd0);
        check_eq("mid_rst_sel", DW'(lane_sel), 32'd0);
        reset = 1'b0;
        clear_model();
        idle(4);
        pair_stream(32'h9000_0000, 32'h9100_0000);
        check_drained("mid_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
